// File: rtl/mantissa_divider_24bit.sv
// Iterative restoring divider for normalized 24-bit floating-point mantissas.
// Produces one quotient bit per cycle (26 bits), then rounds half-up to a 23-bit fraction.
module mantissa_divider_24bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] num1,
  input  logic [23:0] num2,
  output logic [22:0] resultF,
  output logic        normalize,
  output logic        round_ovf,
  output logic        div_zero,
  output logic        busy,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [25:0] rem_q, rem_d;
  logic [23:0] divisor_q, divisor_d;
  logic [25:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [22:0] result_q, result_d;
  logic        norm_q, norm_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic        rem_ge;
  logic [25:0] rem_sub;
  logic [22:0] frac;
  logic        guard;
  logic [23:0] rsum;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    norm_d    = norm_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    ready_d   = ready_q;

    rem_ge  = rem_q >= {2'b00, divisor_q};
    rem_sub = rem_ge ? (rem_q - {2'b00, divisor_q}) : rem_q;

    // Quotient in (0.5, 2): integer bit clear means shift left one place.
    frac  = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
    guard = quo_q[25] ? quo_q[1] : quo_q[0];
    rsum  = {1'b0, frac} + {23'd0, guard};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (num2[23]) begin
            divisor_d = num2;
            rem_d     = {2'b00, num1};
            quo_d     = '0;
            cnt_d     = '0;
            dz_d      = 1'b0;
            busy_d    = 1'b1;
            ready_d   = 1'b0;
            state_d   = CALC;
          end else begin
            result_d  = '0;
            norm_d    = 1'b0;
            ovf_d     = 1'b0;
            dz_d      = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
            state_d   = DONE;
          end
        end
      end
      CALC: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[24:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = ROUND;
      end
      ROUND: begin
        result_d = rsum[22:0];
        ovf_d    = rsum[23];
        norm_d   = ~quo_q[25];
        busy_d   = 1'b0;
        ready_d  = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      norm_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      norm_q    <= norm_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign resultF   = result_q;
  assign normalize = norm_q;
  assign round_ovf = ovf_q;
  assign div_zero  = dz_q;
  assign busy      = busy_q;
  assign ready     = ready_q;

endmodule
